// File: rtl/i2c_mem_slave_if.sv
// Bus bundle between the I2C master side and the memory-mapped I2C target.
// Carries raw SCL/SDA levels, the open-drain pull-down enable and the write-commit strobe.
interface i2c_mem_slave_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic       busy;
   logic       wr_strobe;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;

   modport slave (
      input  scl_in,
      input  sda_in,
      output sda_oe,
      output busy,
      output wr_strobe,
      output wr_addr,
      output wr_data
   );

   modport master (
      output scl_in,
      output sda_in,
      input  sda_oe,
      input  busy,
      input  wr_strobe,
      input  wr_addr,
      input  wr_data
   );
endinterface

// File: rtl/i2c_mem_slave.sv
// I2C target with an auto-incrementing register pointer into a 256x8 register file.
// SCL/SDA are oversampled by clk; SDA is driven open-drain through sda_oe.
module i2c_mem_slave #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   i2c_mem_slave_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      REG,
      REG_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic       rw_q, rw_d;
   logic       oe_q, oe_d;
   logic       strobe_q, strobe_d;
   logic [7:0] waddr_q, waddr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       mem_we;
   logic [7:0] rd_q;
   logic [7:0] mem_q [256];

   logic scl_s, sda_s;
   logic scl_rise, scl_fall;
   logic start_det, stop_det;

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & ~sda_prev_q & sda_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      ptr_d    = ptr_q;
      rw_d     = rw_q;
      oe_d     = oe_q;
      strobe_d = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      mem_we   = 1'b0;
      // Bus conditions outrank any SCL edge seen in the same clk
      if (start_det) begin
         state_d = ADDR;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  cnt_d = 4'd0;
                  if (shift_q[7:1] == SLAVE_ADDR) begin
                     rw_d    = shift_q[0];
                     oe_d    = 1'b1;
                     state_d = ADDR_ACK;
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = 4'd0;
                  if (rw_q) begin
                     shift_d = rd_q;
                     oe_d    = ~rd_q[7];
                     state_d = RDATA;
                  end else begin
                     oe_d    = 1'b0;
                     state_d = REG;
                  end
               end
            end
            REG: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  ptr_d   = shift_q;
                  oe_d    = 1'b1;
                  cnt_d   = 4'd0;
                  state_d = REG_ACK;
               end
            end
            REG_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  oe_d    = 1'b0;
                  cnt_d   = 4'd0;
                  state_d = WDATA;
               end
            end
            WDATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  mem_we   = 1'b1;
                  strobe_d = 1'b1;
                  waddr_d  = ptr_q;
                  wdata_d  = shift_q;
                  ptr_d    = ptr_q + 8'd1;
                  oe_d     = 1'b1;
                  cnt_d    = 4'd0;
                  state_d  = WDATA_ACK;
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     cnt_d   = 4'd0;
                     state_d = RDATA_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     oe_d    = ~shift_q[6];
                  end
               end
            end
            RDATA_ACK: begin
               // cnt marks that the master ACKed; rd_q refetches before the fall
               if (scl_rise) begin
                  ptr_d = ptr_q + 8'd1;
                  if (sda_s) state_d = WAIT_STOP;
                  else       cnt_d   = 4'd1;
               end else if (scl_fall && cnt_q == 4'd1) begin
                  shift_d = rd_q;
                  oe_d    = ~rd_q[7];
                  cnt_d   = 4'd0;
                  state_d = RDATA;
               end
            end
            WAIT_STOP: oe_d = 1'b0;
            default:   state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         shift_q  <= 8'd0;
         ptr_q    <= 8'd0;
         rw_q     <= 1'b0;
         oe_q     <= 1'b0;
         strobe_q <= 1'b0;
         waddr_q  <= 8'd0;
         wdata_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         ptr_q    <= ptr_d;
         rw_q     <= rw_d;
         oe_q     <= oe_d;
         strobe_q <= strobe_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem_q[ptr_q] <= shift_q;
      rd_q <= mem_q[ptr_q];
   end

   assign bus.sda_oe    = oe_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.wr_strobe = strobe_q;
   assign bus.wr_addr   = waddr_q;
   assign bus.wr_data   = wdata_q;
endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: bit-banged I2C master, table of directed transactions,
// hand-written abort/reset sequences and random traffic checked against an array model.
module tb_i2c_mem_slave;
   localparam int Q = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   always #5 clk = ~clk;

   i2c_mem_slave_if bus ();
   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_oe;

   i2c_mem_slave #(
      .SLAVE_ADDR (7'h50),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;
   wr_t wq[$];
   int  oe_cnt      = 0;
   int  oe_idle_bad = 0;

   always @(negedge clk) begin
      if (bus.wr_strobe) wq.push_back({bus.wr_addr, bus.wr_data});
      if (bus.sda_oe) oe_cnt++;
      if (bus.sda_oe && !bus.busy) oe_idle_bad++;
   end

   logic [7:0] mm [256];
   logic [7:0] mptr;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wclk(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; wclk(Q);
      scl_m = 1'b1; wclk(Q);
      sda_m = 1'b0; wclk(Q);
      scl_m = 1'b0; wclk(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; wclk(Q);
      scl_m = 1'b1; wclk(Q);
      sda_m = 1'b1; wclk(Q);
   endtask

   task automatic wbit(bit b);
      sda_m = b;    wclk(Q);
      scl_m = 1'b1; wclk(2 * Q);
      scl_m = 1'b0; wclk(Q);
   endtask

   task automatic rbit(output bit b);
      sda_m = 1'b1; wclk(Q);
      scl_m = 1'b1; wclk(Q);
      b = bus.sda_in; wclk(Q);
      scl_m = 1'b0; wclk(Q);
   endtask

   task automatic wbyte(logic [7:0] v, output bit ack);
      bit n;
      for (int i = 7; i >= 0; i--) wbit(v[i]);
      rbit(n);
      ack = !n;
   endtask

   task automatic rbyte(output logic [7:0] v, input bit ack);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         v[i] = b;
      end
      wbit(!ack);
   endtask

   function automatic logic [7:0] byte_of(logic [31:0] d, int k);
      return d[31-8*k -: 8];
   endfunction

   task automatic do_write(string tag, logic [6:0] dev, logic [7:0] r,
                           int n, logic [31:0] data, bit exp_ack);
      bit  a;
      int  oe0;
      wr_t ew[$];
      wq.delete();
      oe0 = oe_cnt;
      i2c_start;
      wbyte({dev, 1'b0}, a);
      check({tag, "/addr_ack"}, 32'(a), 32'(exp_ack));
      wbyte(r, a);
      if (exp_ack) begin
         check({tag, "/reg_ack"}, 32'(a), 1);
         mptr = r;
      end
      for (int k = 0; k < n; k++) begin
         wbyte(byte_of(data, k), a);
         if (exp_ack) begin
            check({tag, "/data_ack"}, 32'(a), 1);
            ew.push_back({mptr, byte_of(data, k)});
            mm[mptr] = byte_of(data, k);
            mptr = mptr + 8'd1;
         end
      end
      i2c_stop;
      wclk(4);
      check({tag, "/busy_after_stop"}, 32'(bus.busy), 0);
      check({tag, "/strobe_count"}, wq.size(), ew.size());
      for (int k = 0; k < ew.size() && k < wq.size(); k++)
         check({tag, "/strobe_addr_data"}, 32'(wq[k]), 32'(ew[k]));
      if (!exp_ack) check({tag, "/oe_never"}, oe_cnt - oe0, 0);
   endtask

   task automatic do_read(string tag, logic [6:0] dev, logic [7:0] r,
                          int n, logic [31:0] exp);
      bit         a;
      logic [7:0] v;
      i2c_start;
      wbyte({dev, 1'b0}, a);
      check({tag, "/addr_ack"}, 32'(a), 1);
      wbyte(r, a);
      check({tag, "/reg_ack"}, 32'(a), 1);
      mptr = r;
      i2c_start;
      wbyte({dev, 1'b1}, a);
      check({tag, "/raddr_ack"}, 32'(a), 1);
      for (int k = 0; k < n; k++) begin
         rbyte(v, k != n - 1);
         check({tag, "/rdata"}, 32'(v), 32'(byte_of(exp, k)));
         mptr = mptr + 8'd1;
      end
      wclk(2);
      check({tag, "/oe_after_nack"}, 32'(bus.sda_oe), 0);
      i2c_stop;
      wclk(4);
      check({tag, "/busy_after_stop"}, 32'(bus.busy), 0);
   endtask

   typedef struct {
      bit         rd;
      logic [6:0] dev;
      logic [7:0] r;
      int         n;
      logic [31:0] d;
      bit         ack;
   } vec_t;

   vec_t tv[5];

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         a;
      logic [7:0] v;
      logic [31:0] exp;
      int         n, kind;
      logic [7:0] r;
      logic [6:0] dev;

      tv[0] = '{1'b0, 7'h50, 8'h10, 2, 32'hAA55_0000, 1'b1};
      tv[1] = '{1'b0, 7'h42, 8'h33, 0, 32'h0000_0000, 1'b0};
      tv[2] = '{1'b1, 7'h50, 8'h10, 2, 32'hAA55_0000, 1'b1};
      tv[3] = '{1'b0, 7'h50, 8'hFF, 2, 32'h0102_0000, 1'b1};
      tv[4] = '{1'b1, 7'h50, 8'hFF, 2, 32'h0102_0000, 1'b1};

      wclk(3);
      check("reset/sda_oe", 32'(bus.sda_oe), 0);
      check("reset/busy", 32'(bus.busy), 0);
      check("reset/wr_strobe", 32'(bus.wr_strobe), 0);
      check("reset/wr_addr", 32'(bus.wr_addr), 0);
      check("reset/wr_data", 32'(bus.wr_data), 0);
      rst = 1'b0;
      wclk(5);

      for (int i = 0; i < 5; i++) begin
         if (tv[i].rd) do_read($sformatf("vec%0d", i), tv[i].dev, tv[i].r, tv[i].n, tv[i].d);
         else do_write($sformatf("vec%0d", i), tv[i].dev, tv[i].r, tv[i].n, tv[i].d, tv[i].ack);
      end

      // aborted byte: STOP after 4 data bits must not commit anything
      do_write("pre_abort", 7'h50, 8'h20, 1, 32'h7700_0000, 1'b1);
      wq.delete();
      i2c_start;
      wbyte(8'hA0, a);
      wbyte(8'h20, a);
      wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
      i2c_stop;
      wclk(4);
      check("abort/no_strobe", wq.size(), 0);
      check("abort/busy", 32'(bus.busy), 0);
      do_read("abort_rd", 7'h50, 8'h20, 1, {mm[8'h20], 24'h0});

      // reset while the target is pulling SDA during a read
      i2c_start;
      wbyte(8'hA0, a);
      wbyte(8'h11, a);
      i2c_start;
      wbyte(8'hA1, a);
      check("rst_mid/ack", 32'(a), 1);
      check("rst_mid/oe_before", 32'(bus.sda_oe), 1);
      rst = 1'b1;
      wclk(1);
      rst = 1'b0;
      check("rst_mid/oe_after", 32'(bus.sda_oe), 0);
      check("rst_mid/busy_after", 32'(bus.busy), 0);
      wclk(4);
      i2c_start;
      wbyte(8'hA1, a);
      check("rst_mid/ptr0_ack", 32'(a), 1);
      rbyte(v, 1'b0);
      check("rst_mid/ptr0_data", 32'(v), 32'(mm[8'h00]));
      i2c_stop;
      wclk(4);
      do_write("post_rst", 7'h50, 8'h40, 1, 32'h3C00_0000, 1'b1);

      // random traffic over a pre-filled window
      for (int b = 0; b < 4; b++)
         do_write("fill", 7'h50, 8'(8'h80 + 4 * b), 4, $urandom(), 1'b1);
      for (int t = 0; t < 20; t++) begin
         kind = $urandom_range(0, 3);
         r    = 8'(8'h80 + $urandom_range(0, 12));
         n    = $urandom_range(1, 3);
         if (kind <= 1) begin
            do_write("rnd_wr", 7'h50, r, n, $urandom(), 1'b1);
         end else if (kind == 2) begin
            exp = '0;
            for (int k = 0; k < n; k++) exp[31-8*k -: 8] = mm[8'(r + k)];
            do_read("rnd_rd", 7'h50, r, n, exp);
         end else begin
            dev = 7'($urandom_range(0, 127));
            if (dev == 7'h50) dev = 7'h51;
            do_write("rnd_miss", dev, r, n, $urandom(), 1'b0);
         end
      end

      check("oe_only_when_busy", oe_idle_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
